axi_read_arbiter: RTL

//  Parametrised N-port AXI3 read-channel arbiter: merges NUM_PORTS cache/uncached read masters
//  (inst cache, data cache, uncached unit, ...) onto one AXI AR/R channel pair.

---
 rtl/axi_read_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: N-port AXI3 read arbiter, one transaction at a time, round-robin or fixed priority, burst-length check
module axi_read_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 8,
  parameter int ID_W = 4,
  parameter int RR_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        m_arvalid,
  input  logic [NUM_PORTS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_PORTS*LEN_W-1:0]  m_arlen,
  input  logic [NUM_PORTS*2-1:0]      m_arburst,
  output logic [NUM_PORTS-1:0]        m_arready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic [NUM_PORTS-1:0]        m_rvalid,
  output logic [NUM_PORTS-1:0]        m_rlast,
  input  logic [NUM_PORTS-1:0]        m_rready,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [LEN_W-1:0]            arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic [1:0]                  arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic                        busy,
  output logic                        len_err
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state;
  logic [PW-1:0] grant, ptr, win;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0] burst_q;
  logic [LEN_W:0] cnt;
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (m_arvalid[i]) win = PW'(i);
    if (RR_EN != 0)
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (m_arvalid[i] && PW'(i) >= ptr) win = PW'(i);
  end
  always_comb begin
    arvalid = state == AR;
    rready = state == R && m_rready[grant];
    arid = ID_W'(grant);
    araddr = addr_q;
    arlen = len_q;
    arsize = 3'($clog2(DATA_W / 8));
    arburst = burst_q;
    arlock = '0;
    arcache = '0;
    arprot = '0;
    m_arready = (arvalid && arready) ? NUM_PORTS'(1) << grant : '0;
    m_rvalid = (state == R && rvalid) ? NUM_PORTS'(1) << grant : '0;
    m_rlast = (state == R && rlast) ? NUM_PORTS'(1) << grant : '0;
    m_rdata = rdata;
    m_rresp = rresp;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      addr_q <= '0;
      len_q <= '0;
      burst_q <= '0;
      cnt <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: if (|m_arvalid) begin
          grant <= win;
          addr_q <= m_araddr[int'(win)*ADDR_W +: ADDR_W];
          len_q <= m_arlen[int'(win)*LEN_W +: LEN_W];
          burst_q <= m_arburst[int'(win)*2 +: 2];
          state <= AR;
        end
        AR: if (arready) begin
          cnt <= '0;
          state <= R;
        end
        R: if (rvalid && rready) begin
          cnt <= cnt + 1'b1;
          if (rlast) begin
            len_err <= cnt != {1'b0, len_q};
            state <= IDLE;
            if (RR_EN != 0) ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
